// File: rtl/bit_serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor.
// One full-adder slice is reused for every bit, LSB first. A carry flop feeds
// each bit's carry-out back into the next bit's carry-in. Operands arrive over
// a valid/ready handshake; the result and NZCV flags leave over a second one.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);
  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module bit_serial_addsub #(
  parameter  int WIDTH = 64,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, result_q, result_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, flag_c_q, flag_v_q, out_valid_q;
  logic             slice_sum, slice_cout;

  full_adder u_slice (
    .a_i    (sa_q[0]),
    .b_i    (sb_q[0]),
    .cin_i  (carry_q),
    .s_o    (slice_sum),
    .cout_o (slice_cout)
  );

  // The new sum bit enters at the MSB; after WIDTH shifts the result is aligned.
  assign result_d = {slice_sum, result_q[WIDTH-1:1]};

  // Handshake, bit sequencing and flag capture in one state machine.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sa_q    <= a;
            // Subtract is A + ~B + 1; the +1 rides in on the initial carry.
            sb_q    <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sa_q     <= sa_q >> 1;
          sb_q     <= sb_q >> 1;
          result_q <= result_d;
          carry_q  <= slice_cout;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            // Carry-in and carry-out at the MSB give C and V directly.
            flag_c_q    <= slice_cout;
            flag_v_q    <= carry_q ^ slice_cout;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) & reset_n;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_n    = result_q[WIDTH-1];
  // Gated by out_valid so Z reads 0 out of reset, when the result register is 0.
  assign flag_z    = out_valid_q & ~|result_q;
  assign flag_c    = flag_c_q;
  assign flag_v    = flag_v_q;

endmodule

// File: tb/tb_bit_serial_addsub.sv
// Self-checking bench for bit_serial_addsub: directed corner cases plus
// random operations compared against a plain-arithmetic reference model.
`timescale 1ns/1ps

module tb_bit_serial_addsub;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid, in_ready, sub, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic         flag_n, flag_z, flag_c, flag_v;

  int nchk = 0;
  int nerr = 0;

  bit_serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer add/subtract with the usual NZCV definitions.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                output logic [W-1:0] r, output logic n, output logic z,
                                output logic c, output logic v);
    logic [W:0] full;
    if (s) full = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   full = {1'b0, x} + {1'b0, y};
    r = full[W-1:0];
    c = full[W];
    n = r[W-1];
    z = (r == '0);
    if (s) v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else   v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Issue one operation, check latency and outputs, optionally apply
  // backpressure for 'hold' cycles, then complete the output handshake.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input int hold);
    logic [W-1:0] er;
    logic en, ez, ec, ev;
    int k;
    model(x, y, s, er, en, ez, ec, ev);
    k = 0;
    while (!in_ready && k < 10) begin @(negedge clk); k++; end
    chk("in_ready_before_issue", in_ready, 1);
    a = x; b = y; sub = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = $urandom_range(0, 1);
    k = 1;
    while (!out_valid && k < 200) begin @(negedge clk); k++; end
    chk("latency", k, W + 1);
    chk("result", result, er);
    chk("flag_n", flag_n, en);
    chk("flag_z", flag_z, ez);
    chk("flag_c", flag_c, ec);
    chk("flag_v", flag_v, ev);
    if (hold > 0) begin
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_ready", in_ready, 0);
        chk("hold_result", result, er);
        chk("hold_flags", {flag_n, flag_z, flag_c, flag_v}, {en, ez, ec, ev});
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after_hs_ready", in_ready, 1);
    chk("idle_after_hs_valid", out_valid, 0);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_outs", {out_valid, flag_n, flag_z, flag_c, flag_v}, 0);
    chk("rst_result", result, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);

    run_op(64'd5, 64'd3, 1'b0, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
    run_op(64'd0, 64'd1, 1'b1, 0);
    run_op(64'd7, 64'd7, 1'b1, 0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 0);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 10);

    // Reset while the slice is on bit 30 of an operation.
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_outs", {out_valid, flag_n, flag_z, flag_c, flag_v}, 0);
    chk("midrst_result", result, 0);
    @(negedge clk);
    chk("midrst_in_ready2", in_ready, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", in_ready, 1);
    chk("midrst_no_output", out_valid, 0);
    run_op(64'd2, 64'd2, 1'b0, 0);

    // Random operations with random signs and occasional backpressure.
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] x, y;
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if (i % 6 == 0) y = x;
      if (i % 7 == 1) x = {1'b1, x[W-2:0]};
      run_op(x, y, $urandom_range(0, 1), (i % 5 == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
